// File: rtl/result_display_driver_pkg.sv
// Shared types and constants for the result display driver.
//   disp_state_t : conversion FSM states
//   SEG_BLANK / SEG_MINUS : active-high glyphs for an empty position and '-'
//   bcd_adjust() : one double-dabble correction step over all BCD nibbles
package result_display_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } disp_state_t;

    localparam int BCD_DIGITS = 5;
    localparam int DISP_POS   = 6;

    // Segment order is {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Add 3 to every nibble >= 5 so that the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/result_display_driver_seg7_encoder.sv
// Combinational BCD digit to 7-segment glyph, active-high.
//   digit_i : 4-bit decimal digit (10..15 give a blank glyph)
//   glyph_o : segments {g,f,e,d,c,b,a}
module seg7_encoder
    import result_display_driver_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_BLANK;
        case (digit_i)
            4'd0: glyph_o = 7'h3F;
            4'd1: glyph_o = 7'h06;
            4'd2: glyph_o = 7'h5B;
            4'd3: glyph_o = 7'h4F;
            4'd4: glyph_o = 7'h66;
            4'd5: glyph_o = 7'h6D;
            4'd6: glyph_o = 7'h7D;
            4'd7: glyph_o = 7'h07;
            4'd8: glyph_o = 7'h7F;
            4'd9: glyph_o = 7'h6F;
            default: glyph_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display_driver.sv
// Result display driver: captures a signed 16-bit result on the rising edge of
// complete, converts its magnitude to 5 BCD digits by iterative double-dabble
// and scans a 6-position multiplexed 7-segment display (sign + 5 digits).
//   clk, nRST     : clock, asynchronous active-low reset
//   result_in     : two's-complement result
//   complete      : level flag, rising edge means result_in is valid
//   busy          : conversion in progress
//   digits_valid  : one-cycle pulse when bcd_out/negative update
//   negative      : captured result was negative
//   bcd_out       : 5 BCD digits, [3:0] = ones
//   seg           : segments {g,f,e,d,c,b,a}
//   an            : one-hot position enable, [5] = sign, [0] = ones
module result_display_driver
    import result_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [15:0] result_in,
    input  logic        complete,
    output logic        busy,
    output logic        digits_valid,
    output logic        negative,
    output logic [19:0] bcd_out,
    output logic [6:0]  seg,
    output logic [5:0]  an
);

    localparam int            RW           = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_OFF      = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [5:0]    AN_OFF       = (SEG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    disp_state_t   state_q;
    logic          complete_q;
    logic          sign_q;
    logic [15:0]   mag_q;
    logic [3:0]    cnt_q;
    logic [19:0]   scratch_q;
    logic          busy_q;
    logic          dv_q;
    logic          neg_q;
    logic [19:0]   bcd_q;
    logic [RW-1:0] refresh_q;
    logic [2:0]    scan_q;
    logic [6:0]    seg_q;
    logic [5:0]    an_q;

    logic          capture;
    logic [15:0]   mag_d;
    logic [19:0]   scratch_adj;
    logic [3:0]    digit_sel;
    logic [6:0]    enc_glyph;
    logic [7:0]    lz;
    logic [6:0]    glyph_raw;
    logic [6:0]    seg_d;
    logic [5:0]    an_d;

    assign capture     = complete & ~complete_q;
    // Two's-complement negate as unsigned: 0x8000 maps to 32768.
    assign mag_d       = result_in[15] ? (~result_in + 16'd1) : result_in;
    assign scratch_adj = bcd_adjust(scratch_q);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            complete_q <= 1'b0;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            cnt_q      <= '0;
            scratch_q  <= '0;
            busy_q     <= 1'b0;
            dv_q       <= 1'b0;
            neg_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            complete_q <= complete;
            if (capture) begin
                // A new edge always restarts; an in-flight value is dropped.
                sign_q    <= result_in[15];
                mag_q     <= mag_d;
                cnt_q     <= '0;
                scratch_q <= '0;
                busy_q    <= 1'b1;
                dv_q      <= 1'b0;
                state_q   <= SHIFT;
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                        dv_q   <= 1'b0;
                    end
                    SHIFT: begin
                        scratch_q <= {scratch_adj[18:0], mag_q[15]};
                        mag_q     <= {mag_q[14:0], 1'b0};
                        cnt_q     <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q <= DONE;
                        end
                    end
                    DONE: begin
                        bcd_q   <= scratch_q;
                        neg_q   <= sign_q;
                        dv_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        dv_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        case (scan_q)
            3'd0: digit_sel = bcd_q[3:0];
            3'd1: digit_sel = bcd_q[7:4];
            3'd2: digit_sel = bcd_q[11:8];
            3'd3: digit_sel = bcd_q[15:12];
            3'd4: digit_sel = bcd_q[19:16];
            default: digit_sel = 4'd0;
        endcase
    end

    seg7_encoder u_seg7_encoder (
        .digit_i (digit_sel),
        .glyph_o (enc_glyph)
    );

    // lz[i] is set when digit i and every digit above it are zero.
    // Position 0 is left clear so a zero value still shows "0".
    always_comb begin
        lz     = '0;
        lz[4]  = (bcd_q[19:16] == 4'd0);
        for (int i = 3; i >= 1; i--) begin
            lz[i] = lz[i+1] & (bcd_q[i*4 +: 4] == 4'd0);
        end
    end

    always_comb begin
        glyph_raw = enc_glyph;
        if (scan_q == 3'd5) begin
            glyph_raw = neg_q ? SEG_MINUS : SEG_BLANK;
        end else if ((BLANK_LEADING != 0) && lz[scan_q]) begin
            glyph_raw = SEG_BLANK;
        end
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~glyph_raw : glyph_raw;
        an_d  = (SEG_ACTIVE_LOW != 0) ? ~(6'd1 << scan_q) : (6'd1 << scan_q);
    end

    // seg and an are both registered from the same scan index, so they
    // always switch together.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            refresh_q <= '0;
            scan_q    <= '0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
        end else begin
            if (refresh_q == REFRESH_LAST) begin
                refresh_q <= '0;
                scan_q    <= (scan_q == 3'(DISP_POS - 1)) ? 3'd0 : scan_q + 3'd1;
            end else begin
                refresh_q <= refresh_q + RW'(1);
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign busy         = busy_q;
    assign digits_valid = dv_q;
    assign negative     = neg_q;
    assign bcd_out      = bcd_q;
    assign seg          = seg_q;
    assign an           = an_q;

endmodule

// File: tb/tb_result_display_driver.sv
module tb_result_display_driver;

    logic        clk = 1'b0;
    logic        nRST;
    logic [15:0] result_in;
    logic        complete;
    logic        busy;
    logic        digits_valid;
    logic        negative;
    logic [19:0] bcd_out;
    logic [6:0]  seg;
    logic [5:0]  an;

    always #5 clk = ~clk;

    result_display_driver #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1),
        .BLANK_LEADING  (1)
    ) dut (
        .clk          (clk),
        .nRST         (nRST),
        .result_in    (result_in),
        .complete     (complete),
        .busy         (busy),
        .digits_valid (digits_valid),
        .negative     (negative),
        .bcd_out      (bcd_out),
        .seg          (seg),
        .an           (an)
    );

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        int          cap_cyc;
        int          busy_run;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_run = 0;

    bit   disp_en  = 1'b0;
    int   disp_mag = 0;
    bit   disp_neg = 1'b0;
    int   prev_pos = -1;
    int   dwell    = 0;
    bit   seen_change = 1'b0;
    int   m_zeros;
    int   m_pos;
    exp_t m_e;

    // Decimal glyphs, segments {g,f,e,d,c,b,a}, lit = 1
    logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int ref_mag(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [19:0] ref_bcd(input int m);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r[i*4 +: 4] = 4'((m / pow10(i)) % 10);
        return r;
    endfunction

    // Expected active-low segment pattern for a display position.
    function automatic logic [6:0] ref_seg(input int pos, input int m, input bit neg);
        logic [6:0] g;
        if (pos == 5) g = neg ? 7'h40 : 7'h00;
        else if (pos > 0 && m < pow10(pos)) g = 7'h00;
        else g = glyph_tab[(m / pow10(pos)) % 10];
        return ~g;
    endfunction

    task automatic chk(input bit ok, input string name, input string msg);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, msg);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!nRST) begin
            chk(busy == 1'b0 && digits_valid == 1'b0 && negative == 1'b0 &&
                bcd_out == 20'h0 && seg == 7'h7F && an == 6'h3F, "reset_values",
                $sformatf("got busy=%b dv=%b neg=%b bcd=%h seg=%h an=%h, need 0 0 0 00000 7f 3f",
                          busy, digits_valid, negative, bcd_out, seg, an));
            busy_run    = 0;
            prev_pos    = -1;
            seen_change = 1'b0;
        end else begin
            if (digits_valid) begin
                chk(sb_q.size() > 0, "spurious_valid",
                    $sformatf("digits_valid with bcd=%h and nothing expected", bcd_out));
                if (sb_q.size() > 0) begin
                    m_e = sb_q.pop_front();
                    chk(bcd_out == m_e.bcd, "bcd_out",
                        $sformatf("got %h need %h", bcd_out, m_e.bcd));
                    chk(negative == m_e.neg, "negative",
                        $sformatf("got %b need %b", negative, m_e.neg));
                    chk(cyc == m_e.cap_cyc + 17, "latency",
                        $sformatf("valid at edge %0d need %0d", cyc, m_e.cap_cyc + 17));
                    chk(!busy && busy_run == m_e.busy_run, "busy_window",
                        $sformatf("busy=%b run=%0d need busy=0 run=%0d", busy, busy_run, m_e.busy_run));
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].cap_cyc + 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL valid_timeout: no digits_valid by edge %0d, need one at %0d",
                         cyc, sb_q[0].cap_cyc + 17);
                void'(sb_q.pop_front());
            end
            busy_run = busy ? busy_run + 1 : 0;

            if (disp_en) begin
                m_zeros = 0;
                m_pos   = -1;
                for (int i = 0; i < 6; i++) begin
                    if (an[i] == 1'b0) begin
                        m_zeros++;
                        m_pos = i;
                    end
                end
                chk(m_zeros == 1, "an_onehot", $sformatf("got an=%b need exactly one low", an));
                if (m_zeros == 1) begin
                    if (m_pos != prev_pos) begin
                        if (prev_pos >= 0) begin
                            chk(m_pos == (prev_pos + 1) % 6, "scan_order",
                                $sformatf("got position %0d after %0d", m_pos, prev_pos));
                            if (seen_change)
                                chk(dwell == 4, "scan_dwell",
                                    $sformatf("position %0d held %0d clks need 4", prev_pos, dwell));
                            seen_change = 1'b1;
                        end
                        prev_pos = m_pos;
                        dwell    = 1;
                    end else begin
                        dwell++;
                    end
                    chk(seg == ref_seg(m_pos, disp_mag, disp_neg), "seg_glyph",
                        $sformatf("pos %0d got seg=%h need %h (value %0d neg %b)", m_pos, seg,
                                  ref_seg(m_pos, disp_mag, disp_neg), disp_mag, disp_neg));
                end
            end else begin
                prev_pos    = -1;
                seen_change = 1'b0;
            end
        end
    end

    // Stimulus
    task automatic raise(input logic [15:0] v, output int cap);
        @(negedge clk);
        result_in = v;
        complete  = 1'b1;
        cap       = cyc + 1;
    endtask

    task automatic push_exp(input logic [15:0] v, input int cap, input int run);
        exp_t e;
        e.bcd      = ref_bcd(ref_mag(v));
        e.neg      = v[15];
        e.cap_cyc  = cap;
        e.busy_run = run;
        sb_q.push_back(e);
    endtask

    task automatic show(input int m, input bit neg);
        disp_mag = m;
        disp_neg = neg;
        disp_en  = 1'b1;
        repeat (32) @(negedge clk);
        disp_en  = 1'b0;
    endtask

    task automatic convert(input logic [15:0] v, input bit disp);
        int cap;
        raise(v, cap);
        push_exp(v, cap, 17);
        @(negedge clk);
        complete  = 1'b0;
        result_in = 16'($urandom);
        repeat (22) @(negedge clk);
        if (disp) show(ref_mag(v), v[15]);
    endtask

    task automatic retrigger(input logic [15:0] v1, input logic [15:0] v2, input int k);
        int c1, c2;
        raise(v1, c1);
        @(negedge clk);
        complete = 1'b0;
        repeat (k - 2) @(negedge clk);
        raise(v2, c2);
        push_exp(v2, c2, c2 + 17 - c1);
        @(negedge clk);
        complete = 1'b0;
        repeat (22) @(negedge clk);
    endtask

    initial begin
        int cap;
        nRST      = 1'b0;
        complete  = 1'b0;
        result_in = 16'h0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (4) @(negedge clk);
        show(0, 1'b0);

        convert(16'd1234, 1'b1);
        convert(16'hFFFF, 1'b1);
        convert(16'h8000, 1'b1);
        convert(16'h7FFF, 1'b0);
        convert(16'd7, 1'b1);
        convert(16'd0, 1'b1);
        convert(16'd100, 1'b1);

        retrigger(16'd999, 16'd42, 5);
        show(42, 1'b0);
        retrigger(16'd5000, 16'hFF85, 17);
        retrigger(16'd31, 16'd65, 2);

        // Reset in the middle of a conversion
        raise(16'd999, cap);
        @(negedge clk);
        complete = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 nRST = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (30) @(negedge clk);
        show(0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            convert(16'($urandom), (i % 4) == 0);
        end
        for (int i = 0; i < 4; i++) begin
            retrigger(16'($urandom), 16'($urandom), int'($urandom_range(2, 17)));
        end

        repeat (45) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pending_results: %0d expected results never appeared, need 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
